// File: rtl/ccsds123_sample_packer.sv
// Packs a little-endian byte stream into PIPELINES lanes of D-bit samples per AXI-Stream beat,
// marking image ends and flagging short or long images against the byte-level tlast.
module ccsds123_sample_packer #(
  parameter int PIPELINES = 1,
  parameter int D         = 16,
  parameter int NX        = 4,
  parameter int NY        = 2,
  parameter int NZ        = 2
) (
  input  logic                             clk,
  input  logic                             areset,
  input  logic [7:0]                       s_axis_tdata,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  output logic [PIPELINES*D-1:0]           m_axis_tdata,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic [$clog2(PIPELINES+1)-1:0]   m_axis_tlanes,
  output logic                             err_short,
  output logic                             err_long
);

  localparam int SAMPLE_BYTES  = (D + 7) / 8;
  localparam int TOTAL_SAMPLES = NX * NY * NZ;
  localparam int W             = PIPELINES * D;
  localparam int LW            = $clog2(PIPELINES + 1);
  localparam int BW            = (SAMPLE_BYTES > 1) ? $clog2(SAMPLE_BYTES) : 1;
  localparam int CW            = $clog2(TOTAL_SAMPLES + 1);

  logic [BW-1:0] byte_idx_q, byte_idx_d;
  logic [LW-1:0] lane_idx_q, lane_idx_d;
  logic [CW-1:0] sample_cnt_q, sample_cnt_d;
  logic [W-1:0]  acc_data_q, acc_data_d;
  logic          acc_full_q, acc_full_d;
  logic          acc_last_q, acc_last_d;
  logic [LW-1:0] acc_lanes_q, acc_lanes_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [LW-1:0] out_lanes_q, out_lanes_d;
  logic          err_short_q, err_short_d;
  logic          err_long_q, err_long_d;

  logic                      acc_move;
  logic                      accept;
  logic                      sample_done;
  logic                      image_done;
  logic [LW-1:0]             lanes_next;
  logic [SAMPLE_BYTES*8-1:0] byte_vec;
  logic [W-1:0]              lane_vec;

  // ACC drains into OUT whenever OUT is empty or being consumed this cycle.
  assign acc_move      = acc_full_q && (!out_valid_q || m_axis_tready);
  assign s_axis_tready = !areset && (!acc_full_q || acc_move);
  assign accept        = s_axis_tvalid && s_axis_tready;

  assign sample_done = (byte_idx_q == BW'(SAMPLE_BYTES - 1)) || s_axis_tlast;
  assign image_done  = sample_done && (sample_cnt_q == CW'(TOTAL_SAMPLES - 1));
  assign lanes_next  = lane_idx_q + LW'(1);

  // Truncating to D bits drops the unused top bits of the final byte.
  assign byte_vec = (SAMPLE_BYTES*8)'(s_axis_tdata) << {byte_idx_q, 3'b000};
  assign lane_vec = W'(byte_vec[D-1:0]) << (32'(lane_idx_q) * D);

  always_comb begin
    byte_idx_d   = byte_idx_q;
    lane_idx_d   = lane_idx_q;
    sample_cnt_d = sample_cnt_q;
    acc_data_d   = acc_move ? '0 : acc_data_q;
    acc_full_d   = acc_full_q && !acc_move;
    acc_last_d   = acc_last_q;
    acc_lanes_d  = acc_lanes_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_lanes_d  = out_lanes_q;
    err_short_d  = err_short_q;
    err_long_d   = err_long_q;

    if (acc_move) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_data_q;
      out_last_d  = acc_last_q;
      out_lanes_d = acc_lanes_q;
    end else if (m_axis_tready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      acc_data_d = acc_data_d | lane_vec;
      if (sample_done) begin
        byte_idx_d   = '0;
        sample_cnt_d = sample_cnt_q + CW'(1);
        if ((lanes_next == LW'(PIPELINES)) || image_done || s_axis_tlast) begin
          acc_full_d  = 1'b1;
          acc_lanes_d = lanes_next;
          acc_last_d  = image_done || s_axis_tlast;
          lane_idx_d  = '0;
        end else begin
          lane_idx_d  = lanes_next;
        end
        if (image_done || s_axis_tlast) begin
          sample_cnt_d = '0;
        end
        if (s_axis_tlast && !image_done) begin
          err_short_d = 1'b1;
        end
        if (image_done && !s_axis_tlast) begin
          err_long_d = 1'b1;
        end
      end else begin
        byte_idx_d = byte_idx_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      byte_idx_q   <= '0;
      lane_idx_q   <= '0;
      sample_cnt_q <= '0;
      acc_data_q   <= '0;
      acc_full_q   <= 1'b0;
      acc_last_q   <= 1'b0;
      acc_lanes_q  <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_lanes_q  <= '0;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
    end else begin
      byte_idx_q   <= byte_idx_d;
      lane_idx_q   <= lane_idx_d;
      sample_cnt_q <= sample_cnt_d;
      acc_data_q   <= acc_data_d;
      acc_full_q   <= acc_full_d;
      acc_last_q   <= acc_last_d;
      acc_lanes_q  <= acc_lanes_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_lanes_q  <= out_lanes_d;
      err_short_q  <= err_short_d;
      err_long_q   <= err_long_d;
    end
  end

  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tlanes = out_lanes_q;
  assign err_short     = err_short_q;
  assign err_long      = err_long_q;

endmodule

// File: tb/tb_ccsds123_sample_packer.sv
// Bench for ccsds123_sample_packer with D=12, 3 lanes, 32-sample images: byte driver,
// sample-domain expected-beat scoreboard, stall-stability monitor.
module tb_ccsds123_sample_packer;

  localparam int P  = 3;
  localparam int D  = 12;
  localparam int NX = 4;
  localparam int NY = 2;
  localparam int NZ = 4;
  localparam int W  = P * D;
  localparam int LW = $clog2(P + 1);

  logic          clk;
  logic          areset;
  logic [7:0]    s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [W-1:0]  m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;
  logic [LW-1:0] m_tlanes;
  logic          err_short;
  logic          err_long;

  ccsds123_sample_packer #(.PIPELINES(P), .D(D), .NX(NX), .NY(NY), .NZ(NZ)) dut (
    .clk(clk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tlanes(m_tlanes),
    .err_short(err_short), .err_long(err_long)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0]  exp_q[$];
  logic          exp_last_q[$];
  logic [LW-1:0] exp_lanes_q[$];
  logic [7:0]    byte_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int rdy_mode = 0;
  int cyc      = 0;
  int n_stall  = 0;
  int tready_low_cnt = 0;
  bit watch_tready = 1'b0;

  // downstream ready pattern, updated just after each rising edge
  always @(posedge clk) begin
    #1;
    cyc++;
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ((cyc % 3) == 0);
      default: m_tready = ($urandom_range(0, 1) == 1);
    endcase
  end

  // scoreboard and stall monitor, sampled on the falling edge
  bit            prev_stall = 1'b0;
  logic [W-1:0]  prev_data;
  logic          prev_last;
  logic [LW-1:0] prev_lanes;
  logic [W-1:0]  e_data;
  logic          e_last;
  logic [LW-1:0] e_lanes;

  always @(negedge clk) begin
    if (areset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        n_stall++;
        if ({m_tvalid, m_tdata, m_tlast, m_tlanes} !== {1'b1, prev_data, prev_last, prev_lanes})
          $display("FAIL stall_hold: got v=%0b d=%h l=%0b n=%0d, need v=1 d=%h l=%0b n=%0d",
                   m_tvalid, m_tdata, m_tlast, m_tlanes, prev_data, prev_last, prev_lanes);
        else
          n_pass++;
      end
      if (watch_tready && s_tvalid && !s_tready) tready_low_cnt++;
      if (m_tvalid && m_tready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_beat: got d=%h l=%0b n=%0d, need no beat", m_tdata, m_tlast, m_tlanes);
        end else begin
          e_data  = exp_q.pop_front();
          e_last  = exp_last_q.pop_front();
          e_lanes = exp_lanes_q.pop_front();
          if ({m_tdata, m_tlast, m_tlanes} !== {e_data, e_last, e_lanes})
            $display("FAIL beat: got d=%h l=%0b n=%0d, need d=%h l=%0b n=%0d",
                     m_tdata, m_tlast, m_tlanes, e_data, e_last, e_lanes);
          else
            n_pass++;
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
      prev_lanes = m_tlanes;
    end
  end

  // driver tasks: all called at rising edge + 1
  task automatic drive_byte(input logic [7:0] b, input logic last);
    bit rdy;
    int budget;
    s_tdata  = b;
    s_tlast  = last;
    s_tvalid = 1'b1;
    budget   = 0;
    forever begin
      @(negedge clk);
      rdy = s_tready;
      @(posedge clk);
      #1;
      if (rdy) break;
      budget++;
      if (budget > 1000) begin
        n_checks++;
        $display("FAIL byte_accept_timeout: got no accept in %0d cycles, need accept", budget);
        break;
      end
    end
  endtask

  task automatic drive_segment(input int start, input int nbytes, input bit with_tlast);
    for (int i = 0; i < nbytes; i++)
      drive_byte(byte_q[start + i], with_tlast && (i == nbytes - 1));
  endtask

  task automatic idle();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    areset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    areset = 1'b0;
  endtask

  task automatic push_ramp(input int nbytes, input int base);
    for (int i = 0; i < nbytes / 2; i++) begin
      byte_q.push_back(8'((base + i + 1) & 8'hFF));
      byte_q.push_back(8'(((base + i + 1) >> 8) & 8'hFF));
    end
  endtask

  task automatic push_const(input int nbytes, input logic [7:0] v);
    for (int i = 0; i < nbytes; i++) byte_q.push_back(v);
  endtask

  task automatic push_random(input int nbytes);
    for (int i = 0; i < nbytes; i++) byte_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // One image (or one tlast-terminated fragment) of bytes -> expected beats.
  task automatic expect_segment(input int start, input int nbytes);
    int ns;
    int lane;
    logic [7:0]   b0;
    logic [7:0]   b1;
    logic [15:0]  smp16;
    logic [D-1:0] smp;
    logic [W-1:0] beat;
    ns   = (nbytes + 1) / 2;
    lane = 0;
    beat = '0;
    for (int s = 0; s < ns; s++) begin
      b0    = byte_q[start + 2*s];
      b1    = (2*s + 1 < nbytes) ? byte_q[start + 2*s + 1] : 8'h00;
      smp16 = {b1, b0};
      smp   = smp16[D-1:0];
      beat  = beat | (W'(smp) << (lane * D));
      lane++;
      if (lane == P || s == ns - 1) begin
        exp_q.push_back(beat);
        exp_last_q.push_back(s == ns - 1);
        exp_lanes_q.push_back(LW'(lane));
        lane = 0;
        beat = '0;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 3000) begin
      @(posedge clk);
      #1;
      budget++;
    end
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL %s_drain: got %0d beats outstanding, need 0", name, exp_q.size());
    else
      n_pass++;
  endtask

  // tests
  task automatic test_reset();
    areset   = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({m_tvalid, m_tdata, m_tlast, m_tlanes, err_short, err_long, s_tready} !== '0)
      $display("FAIL reset_outputs: got v=%0b d=%h l=%0b n=%0d es=%0b el=%0b rdy=%0b, need all 0",
               m_tvalid, m_tdata, m_tlast, m_tlanes, err_short, err_long, s_tready);
    else
      n_pass++;
    areset = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (s_tready !== 1'b1)
      $display("FAIL reset_release_ready: got %0b, need 1", s_tready);
    else
      n_pass++;
  endtask

  task automatic test_ramp();
    rdy_mode = 0;
    byte_q.delete();
    push_ramp(64, 0);
    expect_segment(0, 64);
    tready_low_cnt = 0;
    watch_tready   = 1'b1;
    drive_segment(0, 64, 1'b1);
    idle();
    wait_drain("ramp");
    watch_tready = 1'b0;
    n_checks++;
    if (tready_low_cnt !== 0)
      $display("FAIL ramp_tready: got %0d stalled byte cycles, need 0", tready_low_cnt);
    else
      n_pass++;
    n_checks++;
    if ({err_short, err_long} !== 2'b00)
      $display("FAIL ramp_errors: got es=%0b el=%0b, need 0 0", err_short, err_long);
    else
      n_pass++;
  endtask

  task automatic test_all_ones();
    byte_q.delete();
    push_const(64, 8'hFF);
    expect_segment(0, 64);
    drive_segment(0, 64, 1'b1);
    idle();
    wait_drain("all_ones");
  endtask

  task automatic test_backpressure();
    byte_q.delete();
    push_ramp(64, 0);
    expect_segment(0, 64);
    n_stall  = 0;
    rdy_mode = 1;
    drive_segment(0, 64, 1'b1);
    idle();
    wait_drain("backpressure");
    rdy_mode = 0;
    n_checks++;
    if (n_stall == 0)
      $display("FAIL backpressure_stalls: got 0 stalled beats, need some");
    else
      n_pass++;
  endtask

  task automatic test_early_tlast();
    do_reset();
    byte_q.delete();
    push_ramp(20, 0);
    push_random(3);
    push_ramp(64, 8'h40);
    expect_segment(0, 20);
    expect_segment(20, 3);
    expect_segment(23, 64);
    drive_segment(0, 20, 1'b1);
    drive_segment(20, 3, 1'b1);
    drive_segment(23, 64, 1'b1);
    idle();
    wait_drain("early_tlast");
    n_checks++;
    if ({err_short, err_long} !== 2'b10)
      $display("FAIL early_tlast_flags: got es=%0b el=%0b, need 1 0", err_short, err_long);
    else
      n_pass++;
  endtask

  task automatic test_long();
    do_reset();
    byte_q.delete();
    push_ramp(64, 0);
    push_ramp(64, 12'h200);
    expect_segment(0, 64);
    expect_segment(64, 64);
    drive_segment(0, 64, 1'b0);
    n_checks++;
    if ({err_short, err_long} !== 2'b01)
      $display("FAIL long_flag_after_image: got es=%0b el=%0b, need 0 1", err_short, err_long);
    else
      n_pass++;
    drive_segment(64, 64, 1'b1);
    idle();
    wait_drain("long");
    n_checks++;
    if ({err_short, err_long} !== 2'b01)
      $display("FAIL long_flag_sticky: got es=%0b el=%0b, need 0 1", err_short, err_long);
    else
      n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    byte_q.delete();
    push_random(3);
    push_ramp(64, 8'h80);
    drive_segment(0, 3, 1'b0);
    idle();
    areset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({m_tvalid, m_tdata, m_tlast, m_tlanes, err_short, err_long, s_tready} !== '0)
      $display("FAIL reset_mid_outputs: got v=%0b d=%h l=%0b n=%0d es=%0b el=%0b rdy=%0b, need all 0",
               m_tvalid, m_tdata, m_tlast, m_tlanes, err_short, err_long, s_tready);
    else
      n_pass++;
    areset = 1'b0;
    expect_segment(3, 64);
    drive_segment(3, 64, 1'b1);
    idle();
    wait_drain("reset_mid");
  endtask

  task automatic test_back_to_back();
    rdy_mode = 2;
    byte_q.delete();
    push_random(128);
    expect_segment(0, 64);
    expect_segment(64, 64);
    drive_segment(0, 64, 1'b1);
    drive_segment(64, 64, 1'b1);
    idle();
    wait_drain("back_to_back");
    rdy_mode = 0;
    n_checks++;
    if ({err_short, err_long} !== 2'b00)
      $display("FAIL back_to_back_errors: got es=%0b el=%0b, need 0 0", err_short, err_long);
    else
      n_pass++;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_all_ones();
    test_backpressure();
    test_early_tlast();
    test_long();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ccsds123_sample_packer.md
Name: ccsds123_sample_packer

Overview:
Front-end feeder for ccsds123_top. Consumes the raw image byte stream in the team's .bin layout: each sample is SAMPLE_BYTES = ceil(D/8) bytes, little-endian, in BIP/BSQ order as stored. Assembles PIPELINES samples per beat into the compressor's PIPELINES*D-bit AXI-Stream input. Marks the final beat of each NX*NY*NZ-sample image and flags byte-stream framing errors. Sits between the DMA/byte source and ccsds123_top.s_axis.

Parameters:
PIPELINES, 1, samples per output beat (lanes).
D, 16, sample bit width (2..32).
NX, 4, image width in samples.
NY, 2, image height in samples.
NZ, 2, number of bands.
Derived (localparam): SAMPLE_BYTES=(D+7)/8; TOTAL_SAMPLES=NX*NY*NZ.

Ports:
clk  in  1  clock, all logic on rising edge.
areset  in  1  synchronous, active-high reset.
s_axis_tdata  in  8  input byte.
s_axis_tvalid  in  1  byte valid.
s_axis_tready  out  1  byte accepted when tvalid&&tready.
s_axis_tlast  in  1  last byte of image from source.
m_axis_tdata  out  PIPELINES*D  lane k = bits [k*D +: D]; lane 0 = earliest sample.
m_axis_tvalid  out  1  beat valid.
m_axis_tready  in  1  downstream ready.
m_axis_tlast  out  1  beat holds sample TOTAL_SAMPLES-1 (or flushed short image).
m_axis_tlanes  out  $clog2(PIPELINES+1)  number of valid lanes in beat (1..PIPELINES).
err_short  out  1  sticky: s_axis_tlast before image complete.
err_long  out  1  sticky: image complete but last byte lacked s_axis_tlast.

Behaviour:
- Reset (areset=1 at clk edge): m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tlanes=0, err_short=0, err_long=0, s_axis_tready=0 during reset, 1 the cycle after. All counters (byte_idx, lane_idx, sample_cnt) and both registers are cleared. Reset mid-image discards partial data. No beat is emitted for it.
- Byte assembly: byte b of a sample goes to sample bits [b*8 +: 8]. Bits at and above D of the last byte are dropped. Unused lanes in a partial beat are driven to 0.
- Two-stage buffer: accumulation register (ACC) and output register (OUT).
  - When ACC completes, it moves to OUT if OUT is empty or OUT is handed off this cycle. ACC completes when lane_idx reaches PIPELINES, at the final image sample, or at an early tlast.
  - Otherwise ACC holds full and s_axis_tready=0.
  - s_axis_tready = !(ACC_full && OUT_valid && !m_axis_tready).
  - Sustains 1 byte/cycle with m_axis_tready=1.
- Latency: the byte completing a beat accepted at edge N gives m_axis_tvalid=1 after edge N+1.
- AXI rules: while m_axis_tvalid=1 && m_axis_tready=0, tdata/tlast/tlanes are held stable. tvalid never deasserts without a handshake.
- Image end, normal: the last byte of sample TOTAL_SAMPLES-1 completes the beat. m_axis_tlast=1, tlanes = remainder lanes (PIPELINES if divisible). sample_cnt wraps to 0 and the next byte starts a new image.
  - If that byte has s_axis_tlast=0, set err_long.
  - Subsequent bytes are packed normally as the next image.
- Early tlast: s_axis_tlast=1 on a byte that completes sample k < TOTAL_SAMPLES-1.
  - Flush ACC with m_axis_tlast=1 and tlanes = lanes filled.
  - Set err_short and restart counters.
  - If tlast arrives mid-sample (byte_idx != SAMPLE_BYTES-1), the partial sample is zero-extended and counted as a lane.
- Simultaneous events: OUT handshake and ACC transfer in the same cycle are legal with no bubble. The error flags stay set until areset.

Test Plan:
1. D=16, PIPELINES=1, 32 samples of bytes 0x01,0x00,0x02,0x00,... with tlast on byte 63, m_tready=1 -> 32 beats 0x0001,0x0002,...; tlast only on beat 32; no error flags; s_tready always 1.
2. D=12, PIPELINES=3, 32 samples, each byte pair 0xFF,0xFF -> 11 beats, lanes=0xFFF. Beat 11 has tlanes=2, lane2=0, tlast=1.
3. Backpressure: toggle m_tready 1-in-3 cycles over a full image -> output stream matches test 1 exactly; tdata stable while stalled; no lost or duplicated samples.
4. s_axis_tlast on byte 19 (sample 9, PIPELINES=4) -> beat with tlanes=2, tlast=1; err_short=1. The next byte starts lane 0 of a new image.
5. Full image with no tlast, then a second image -> err_long=1 after byte 63. The second image is packed correctly with its own tlast beat.
6. areset asserted mid-beat (after 3 bytes), then a full image -> no beat from the discarded bytes; outputs zero during reset; the following image is correct.
